// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers hex digits from a multiplexed, active-low
// 8-digit seven-segment display bus. A sample is committed only after it
// has been stable for STABLE_CYCLES clocks. Committed digits collect in
// shadow registers until all eight have been seen. The complete frame is
// then published on data_out/dp_out.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  anode,
  input  logic [6:0]  cathode,
  input  logic        dp,
  output logic [31:0] data_out,
  output logic [7:0]  dp_out,
  output logic        frame_valid,
  output logic [7:0]  digit_mask,
  output logic        err_multi,
  output logic        err_pattern
);

  // The counter saturates one step past the commit value. A long stable
  // run therefore produces exactly one commit.
  localparam int CNT_W = $clog2(STABLE_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_COMMIT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [15:0]      sample;
  logic [15:0]      cur_sample;
  logic [CNT_W-1:0] stable_cnt;
  logic [31:0]      shadow;
  logic [7:0]       shadow_dp;

  logic [31:0]      shadow_next;
  logic [7:0]       shadow_dp_next;
  logic [7:0]       mask_next;
  logic [7:0]       sel;
  logic [4:0]       dec;
  logic             commit;
  logic             blank;
  logic             multi;
  logic             hit;
  logic [3:0]       nibble;

  // Cathode {g..a} pattern to {hit, nibble}; unknown patterns return hit=0.
  function automatic logic [4:0] decode_hex(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  assign cur_sample = {anode, cathode, dp};
  assign sel        = ~sample[15:8];
  assign commit     = (stable_cnt == CNT_COMMIT);
  assign blank      = (sel == 8'h00);
  assign multi      = ((sel & (sel - 8'd1)) != 8'h00);
  assign dec        = decode_hex(sample[7:1]);
  assign hit        = dec[4];
  assign nibble     = dec[3:0];

  // Register the bus sample and count how long it has stayed unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample     <= 16'hFFFF;
      stable_cnt <= '0;
    end else begin
      if (cur_sample == sample) begin
        if (stable_cnt < CNT_MAX) stable_cnt <= stable_cnt + CNT_ONE;
      end else begin
        stable_cnt <= CNT_ONE;
      end
      sample <= cur_sample;
    end
  end

  // Shadow contents as they would look if the committed digit is stored.
  always_comb begin
    shadow_next    = shadow;
    shadow_dp_next = shadow_dp;
    mask_next      = digit_mask | sel;
    for (int i = 0; i < 8; i++) begin
      if (sel[i]) begin
        shadow_next[4*i +: 4] = nibble;
        shadow_dp_next[i]     = ~sample[0];
      end
    end
  end

  // Commit handling: error pulses, digit store, and frame publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      dp_out      <= '0;
      frame_valid <= 1'b0;
      digit_mask  <= '0;
      err_multi   <= 1'b0;
      err_pattern <= 1'b0;
      shadow      <= '0;
      shadow_dp   <= '0;
    end else begin
      frame_valid <= 1'b0;
      err_multi   <= 1'b0;
      err_pattern <= 1'b0;
      if (commit && !blank) begin
        if (multi) begin
          err_multi <= 1'b1;
        end else if (!hit) begin
          err_pattern <= 1'b1;
        end else begin
          shadow    <= shadow_next;
          shadow_dp <= shadow_dp_next;
          if (&mask_next) begin
            data_out    <= shadow_next;
            dp_out      <= shadow_dp_next;
            frame_valid <= 1'b1;
            digit_mask  <= '0;
          end else begin
            digit_mask <= mask_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: scoreboard bench for seg_scan_decoder.
// Expected frame/error pulses are queued as stimulus is driven. A negedge
// monitor pops and compares them whenever the DUT raises a pulse.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  anode = 8'hFF;
  logic [6:0]  cathode = 7'h7F;
  logic        dp = 1'b1;
  logic [31:0] data_out;
  logic [7:0]  dp_out;
  logic        frame_valid;
  logic [7:0]  digit_mask;
  logic        err_multi;
  logic        err_pattern;

  int assert_count = 0;
  int fail_count = 0;

  // Pulse kinds as {frame_valid, err_multi, err_pattern}.
  localparam logic [2:0] K_FRAME = 3'b100;
  localparam logic [2:0] K_MULTI = 3'b010;
  localparam logic [2:0] K_PATT  = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] data;
    logic [7:0]  dpv;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .anode(anode),
    .cathode(cathode),
    .dp(dp),
    .data_out(data_out),
    .dp_out(dp_out),
    .frame_valid(frame_valid),
    .digit_mask(digit_mask),
    .err_multi(err_multi),
    .err_pattern(err_pattern)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one bus value and hold it for a number of clocks (starts and ends on a negedge).
  task automatic applyStimulus(input logic [7:0] an, input logic [6:0] cat, input logic dpv, input int cycles);
    anode   = an;
    cathode = cat;
    dp      = dpv;
    repeat (cycles) @(negedge clk);
  endtask

  // Show hex digit nib on digit k, optionally with its point lit.
  task automatic scanDigit(input int k, input logic [3:0] nib, input logic dp_on, input int cycles);
    logic [7:0] an;
    an = ~(8'h01 << k);
    applyStimulus(an, seg_tab[nib], ~dp_on, cycles);
  endtask

  task automatic pushExp(input logic [2:0] kind, input logic [31:0] data, input logic [7:0] dpv);
    exp_t e;
    e.kind = kind;
    e.data = data;
    e.dpv  = dpv;
    sbq.push_back(e);
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (frame_valid || err_multi || err_pattern) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_pulse", {29'd0, frame_valid, err_multi, err_pattern}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        checkOutput("pulse_kind", {29'd0, frame_valid, err_multi, err_pattern}, {29'd0, mon_e.kind});
        if (mon_e.kind == K_FRAME) begin
          checkOutput("frame_data", data_out, mon_e.data);
          checkOutput("frame_dp", {24'd0, dp_out}, {24'd0, mon_e.dpv});
          checkOutput("frame_mask_clear", {24'd0, digit_mask}, 32'd0);
        end
      end
    end
  end

  initial begin
    logic [31:0] val;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_data", data_out, 32'd0);
    checkOutput("rst_dp", {24'd0, dp_out}, 32'd0);
    checkOutput("rst_mask", {24'd0, digit_mask}, 32'd0);
    checkOutput("rst_pulses", {29'd0, frame_valid, err_multi, err_pattern}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(8'hFF, 7'h7F, 1'b1, 6);

    // Normal frame, with a latency check on digit 0.
    $display("[TB] normal frame");
    val = 32'h12345678;
    pushExp(K_FRAME, val, 8'h00);
    scanDigit(0, val[3:0], 1'b0, 4);
    checkOutput("latency_before", {24'd0, digit_mask}, 32'h00);
    @(negedge clk);
    checkOutput("latency_at", {24'd0, digit_mask}, 32'h01);
    repeat (3) @(negedge clk);
    for (int k = 1; k < 8; k++) scanDigit(k, val[4*k +: 4], 1'b0, 8);
    applyStimulus(8'hFF, 7'h7F, 1'b1, 6);
    checkOutput("normal_data", data_out, 32'h12345678);
    checkOutput("normal_mask", {24'd0, digit_mask}, 32'd0);
    checkOutput("normal_sb_empty", sbq.size(), 32'd0);

    // Glitch filter on digit 3, then complete a frame around it.
    $display("[TB] glitch filter");
    applyStimulus(8'hF7, 7'h79, 1'b1, 2);
    applyStimulus(8'hF7, 7'h30, 1'b1, 2);
    checkOutput("glitch_mask_mid", {24'd0, digit_mask}, 32'h00);
    applyStimulus(8'hF7, 7'h30, 1'b1, 6);
    checkOutput("glitch_mask", {24'd0, digit_mask}, 32'h08);
    val = 32'h76543210;
    pushExp(K_FRAME, val, 8'h22);
    for (int k = 0; k < 8; k++)
      if (k != 3) scanDigit(k, val[4*k +: 4], (k == 1) || (k == 5), 8);
    applyStimulus(8'hFF, 7'h7F, 1'b1, 6);
    checkOutput("glitch_data_hold", data_out, 32'h76543210);
    checkOutput("glitch_sb_empty", sbq.size(), 32'd0);

    // Bad pattern and multi-anode errors leave a partial frame intact.
    $display("[TB] error pulses");
    scanDigit(1, 4'h9, 1'b0, 8);
    checkOutput("err_pre_mask", {24'd0, digit_mask}, 32'h02);
    pushExp(K_PATT, 32'd0, 8'd0);
    applyStimulus(8'hFE, 7'h7F, 1'b1, 6);
    checkOutput("patt_mask", {24'd0, digit_mask}, 32'h02);
    pushExp(K_MULTI, 32'd0, 8'd0);
    applyStimulus(8'hFC, seg_tab[8], 1'b1, 6);
    checkOutput("multi_mask", {24'd0, digit_mask}, 32'h02);
    checkOutput("err_data_hold", data_out, 32'h76543210);
    checkOutput("err_sb_empty", sbq.size(), 32'd0);

    // Reset mid-frame discards partial digits.
    $display("[TB] reset mid-frame");
    scanDigit(0, 4'h1, 1'b0, 8);
    scanDigit(2, 4'h2, 1'b0, 8);
    scanDigit(3, 4'h3, 1'b0, 8);
    checkOutput("pre_rst_mask", {24'd0, digit_mask}, 32'h0F);
    applyStimulus(8'hFF, 7'h7F, 1'b1, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_data", data_out, 32'd0);
    checkOutput("midrst_dp", {24'd0, dp_out}, 32'd0);
    checkOutput("midrst_mask", {24'd0, digit_mask}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(8'hFF, 7'h7F, 1'b1, 6);
    val = 32'hDEADBEEF;
    for (int k = 4; k < 8; k++) scanDigit(k, val[4*k +: 4], k == 7, 8);
    checkOutput("postrst_half_mask", {24'd0, digit_mask}, 32'hF0);
    pushExp(K_FRAME, val, 8'h80);
    for (int k = 0; k < 4; k++) scanDigit(k, val[4*k +: 4], 1'b0, 8);
    applyStimulus(8'hFF, 7'h7F, 1'b1, 6);
    checkOutput("postrst_data", data_out, 32'hDEADBEEF);
    checkOutput("postrst_dp", {24'd0, dp_out}, 32'h80);
    checkOutput("postrst_sb_empty", sbq.size(), 32'd0);

    // Reverse order with digit 2 overwritten (8 with point, then 5 without).
    $display("[TB] overwrite / out of order");
    val = 32'h9ABCD5F1;
    pushExp(K_FRAME, val, 8'h00);
    for (int k = 7; k >= 0; k--) begin
      if (k == 2) scanDigit(2, 4'h8, 1'b1, 8);
      scanDigit(k, val[4*k +: 4], 1'b0, 8);
    end
    applyStimulus(8'hFF, 7'h7F, 1'b1, 10);
    checkOutput("ovr_data", data_out, 32'h9ABCD5F1);
    checkOutput("ovr_dp", {24'd0, dp_out}, 32'h00);
    checkOutput("ovr_mask", {24'd0, digit_mask}, 32'd0);
    checkOutput("final_sb_empty", sbq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 The block SHALL have one parameter: STABLE_CYCLES, default 4, the number of consecutive identical bus samples (min 1) required before a digit is committed.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous and active-low.
REQ-004 anode  input  8  digit enables, active-low; anode[k]=0 selects digit k.
REQ-005 cathode  input  7  segment drives, active-low; cathode[0]=a ... cathode[6]=g.
REQ-006 dp  input  1  decimal point, active-low.
REQ-007 data_out  output  32  last complete frame; digit k occupies bits [4k+3:4k].
REQ-008 dp_out  output  8  last complete frame decimal points; dp_out[k]=1 means the point on digit k is lit.
REQ-009 frame_valid  output  1  one-cycle pulse when data_out/dp_out update.
REQ-010 digit_mask  output  8  digits committed in the current (incomplete) frame.
REQ-011 err_multi  output  1  one-cycle pulse: more than one anode low in a stable sample.
REQ-012 err_pattern  output  1  one-cycle pulse: stable cathode value not in the hex table.

Function
REQ-013 Each cycle the block SHALL register the sample S={anode,cathode,dp} and compare it against the previous registered sample.
REQ-014 Stability counter: it SHALL increment, saturating, while S is unchanged, and SHALL reload to 1 when S changes.
REQ-015 Commit point: exactly one commit event SHALL occur per run of identical samples, in the cycle the counter first equals STABLE_CYCLES.
REQ-016 At a commit event with anode all-ones (blanking), no action SHALL be taken.
REQ-017 At a commit event with two or more anode bits low, err_multi SHALL pulse on the next edge, and no digit SHALL be stored.
REQ-018 At a commit event with exactly one anode bit low (k), the block SHALL decode cathode using hex table REQ-019.
REQ-018a On a decode miss, err_pattern SHALL pulse on the next edge, with no store.
REQ-018b On a decode hit, the nibble SHALL go to shadow[k], ~dp SHALL go to shadow_dp[k], and digit_mask[k] SHALL be set.
REQ-019 Hex table, cathode {g..a} hex to nibble: 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9, 08=A, 03=B, 46=C, 21=D, 06=E, 0E=F.
REQ-020 Re-commit of a digit already set in digit_mask SHALL overwrite shadow[k] and shadow_dp[k].
REQ-021 Frame completion: a commit that makes digit_mask all-ones SHALL trigger these updates on the same edge that stores the digit:
- data_out SHALL take the shadow values including the new nibble;
- dp_out SHALL take shadow_dp;
- frame_valid SHALL be 1 for exactly that one cycle;
- digit_mask SHALL clear to 0.
REQ-022 Latency from the first cycle of a stable sample on the pins to digit_mask/frame_valid reflecting it SHALL be STABLE_CYCLES+1 clocks.
REQ-023 data_out and dp_out SHALL hold their values between frame completions.
REQ-024 Digit order SHALL be arbitrary: any scan order completing all 8 digits SHALL produce a frame.
REQ-025 The error pulses SHALL be mutually exclusive with a store in the same cycle; errors SHALL NOT clear digit_mask.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously force the following to 0:
- data_out, dp_out, digit_mask, frame_valid, err_multi, err_pattern;
- the shadow registers and the stability counter.
REQ-027 On rst_n low, the previous-sample register SHALL be forced to all-ones, which is the blanking value.
REQ-028 A reset mid-frame SHALL discard partial digits; after release, a full 8-digit scan is required before frame_valid.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Normal frame: scan 32'h12345678 (dp all off), digits 0..7, each held 8 cycles, STABLE_CYCLES=4 -> frame_valid once, data_out=32'h12345678, dp_out=8'h00, digit_mask=0 afterwards.
- Glitch filter: digit 3 shows cathode 7'h79 for 2 cycles, then 7'h30 for 8 cycles -> nibble 3 stored, no error pulse, 7'h79 never committed.
- Bad pattern: anode=8'hFE, cathode=7'h7F held 6 cycles -> err_pattern pulses once, digit_mask unchanged.
- Multi-anode: anode=8'hFC held 6 cycles -> err_multi pulses once, no store.
- Reset mid-frame: commit digits 0..3, assert rst_n low for 1 cycle -> all outputs 0 immediately; next full scan of 32'hDEADBEEF with dp on digit 7 -> data_out=32'hDEADBEEF, dp_out=8'h80.
- Overwrite/out-of-order: scan digits 7..0, with digit 2 scanned twice (8 then 5) -> data_out nibble 2 equals 5, single frame_valid.
